// File: rtl/multicycle_controller_pkg.sv
// Fixed encodings shared by the multicycle MIPS controller: states, opcodes,
// funct codes, ALU control codes and datapath select codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // State that follows DECODE for a given opcode; FETCH marks an unsupported op.
  function automatic state_t decode_target(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW: return S_MEMADR;
      OP_RTYPE:     return S_EXECUTE;
      OP_BEQ:       return S_BRANCH;
      OP_ADDI:      return S_ADDIEX;
      OP_J:         return S_JUMP;
      default:      return S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the shared datapath.
interface multicycle_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pcen;
  logic       irwrite;
  logic       memwrite;
  logic       regwrite;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;

  modport master (
    input  op, funct, zero, mem_ready,
    output pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
           alusrca, alusrcb, pcsrc, alucontrol, illegal
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
           alusrca, alusrcb, pcsrc, alucontrol, illegal
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// R-type funct to ALU control mapping; unknown functs flag illegal and fall back to add.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_illegal
);

  always_comb begin
    alucontrol    = ALU_ADD;
    funct_illegal = 1'b0;
    case (funct)
      FN_ADD:  alucontrol = ALU_ADD;
      FN_SUB:  alucontrol = ALU_SUB;
      FN_AND:  alucontrol = ALU_AND;
      FN_OR:   alucontrol = ALU_OR;
      FN_SLT:  alucontrol = ALU_SLT;
      default: funct_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the shared multicycle MIPS datapath, one state per cycle,
// stalling in FETCH/MEMREAD/MEMWRITE until memory reports mem_ready.
module multicycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  state_t     state_reg;
  logic [5:0] op_q;
  logic [5:0] funct_q;
  logic [2:0] ex_alucontrol;
  logic       funct_illegal;
  logic       pcwrite;
  logic       branch;

  alu_decoder u_alu_decoder (
    .funct         (funct_q),
    .alucontrol    (ex_alucontrol),
    .funct_illegal (funct_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
      op_q      <= 6'd0;
      funct_q   <= 6'd0;
    end else begin
      case (state_reg)
        S_FETCH:    if (bus.mem_ready) state_reg <= S_DECODE;
        S_DECODE: begin
          op_q      <= bus.op;
          funct_q   <= bus.funct;
          state_reg <= decode_target(bus.op);
        end
        S_MEMADR: begin
          if (op_q == OP_LW)      state_reg <= S_MEMREAD;
          else if (op_q == OP_SW) state_reg <= S_MEMWRITE;
          else                    state_reg <= S_FETCH;
        end
        S_MEMREAD:  if (bus.mem_ready) state_reg <= S_MEMWB;
        S_MEMWB:    state_reg <= S_FETCH;
        S_MEMWRITE: if (bus.mem_ready) state_reg <= S_FETCH;
        S_EXECUTE:  state_reg <= funct_illegal ? S_FETCH : S_ALUWB;
        S_ALUWB:    state_reg <= S_FETCH;
        S_BRANCH:   state_reg <= S_FETCH;
        S_ADDIEX:   state_reg <= S_ADDIWB;
        S_ADDIWB:   state_reg <= S_FETCH;
        S_JUMP:     state_reg <= S_FETCH;
        default:    state_reg <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pcwrite        = 1'b0;
    branch         = 1'b0;
    bus.irwrite    = 1'b0;
    bus.memwrite   = 1'b0;
    bus.regwrite   = 1'b0;
    bus.iord       = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.regdst     = 1'b0;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = SRCB_REGB;
    bus.pcsrc      = PCSRC_ALU;
    bus.alucontrol = ALU_ADD;
    bus.illegal    = 1'b0;
    case (state_reg)
      S_FETCH: begin
        bus.alusrcb = SRCB_FOUR;
        if (bus.mem_ready) begin
          bus.irwrite = 1'b1;
          pcwrite     = 1'b1;
        end
      end
      S_DECODE: begin
        bus.alusrcb = SRCB_IMM_SH2;
        bus.illegal = (decode_target(bus.op) == S_FETCH);
      end
      S_MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = SRCB_IMM;
      end
      S_MEMREAD:  bus.iord = 1'b1;
      S_MEMWB: begin
        bus.memtoreg = 1'b1;
        bus.regwrite = 1'b1;
      end
      S_MEMWRITE: begin
        bus.iord     = 1'b1;
        bus.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = ex_alucontrol;
        bus.illegal    = funct_illegal;
      end
      S_ALUWB: begin
        bus.regdst   = 1'b1;
        bus.regwrite = 1'b1;
      end
      S_BRANCH: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = ALU_SUB;
        bus.pcsrc      = PCSRC_ALUOUT;
        branch         = 1'b1;
      end
      S_ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = SRCB_IMM;
      end
      S_ADDIWB:   bus.regwrite = 1'b1;
      S_JUMP: begin
        bus.pcsrc = PCSRC_JUMP;
        pcwrite   = 1'b1;
      end
      default:    bus.alucontrol = 3'b000;
    endcase

    // Reset silences every strobe so an abandoned instruction cannot write.
    if (reset) begin
      pcwrite        = 1'b0;
      branch         = 1'b0;
      bus.irwrite    = 1'b0;
      bus.memwrite   = 1'b0;
      bus.regwrite   = 1'b0;
      bus.iord       = 1'b0;
      bus.memtoreg   = 1'b0;
      bus.regdst     = 1'b0;
      bus.alusrca    = 1'b0;
      bus.alusrcb    = 2'b00;
      bus.pcsrc      = 2'b00;
      bus.alucontrol = 3'b000;
      bus.illegal    = 1'b0;
    end
    bus.pcen = pcwrite | (branch & bus.zero);
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: each stimulus cycle queues its expected output vector; a negedge monitor compares.
module tb_multicycle_controller;

  logic clk;
  logic reset;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic [15:0] exp;
  } item_t;

  item_t sb_q[$];
  int    checks = 0;
  int    errors = 0;

  // {pcen,irwrite,memwrite,regwrite,iord,memtoreg,regdst,alusrca,alusrcb,pcsrc,alucontrol,illegal}
  function automatic logic [15:0] ev(input logic pcen, input logic irw, input logic mw,
                                     input logic rw, input logic iord, input logic mtr,
                                     input logic rd, input logic asa, input logic [1:0] asb,
                                     input logic [1:0] pcs, input logic [2:0] alu,
                                     input logic ill);
    return {pcen, irw, mw, rw, iord, mtr, rd, asa, asb, pcs, alu, ill};
  endfunction

  logic [15:0] e_reset, e_fetch, e_fetch_wait, e_decode, e_decode_ill, e_memadr;
  logic [15:0] e_memread, e_memwb, e_memwrite, e_exec_sub, e_exec_ill, e_aluwb;
  logic [15:0] e_branch_z, e_branch_nz, e_addiex, e_addiwb, e_jump;

  initial begin
    e_reset      = ev(0,0,0,0,0,0,0,0,2'b00,2'b00,3'b000,0);
    e_fetch      = ev(1,1,0,0,0,0,0,0,2'b01,2'b00,3'b010,0);
    e_fetch_wait = ev(0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0);
    e_decode     = ev(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0);
    e_decode_ill = ev(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,1);
    e_memadr     = ev(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0);
    e_memread    = ev(0,0,0,0,1,0,0,0,2'b00,2'b00,3'b010,0);
    e_memwb      = ev(0,0,0,1,0,1,0,0,2'b00,2'b00,3'b010,0);
    e_memwrite   = ev(0,0,1,0,1,0,0,0,2'b00,2'b00,3'b010,0);
    e_exec_sub   = ev(0,0,0,0,0,0,0,1,2'b00,2'b00,3'b110,0);
    e_exec_ill   = ev(0,0,0,0,0,0,0,1,2'b00,2'b00,3'b010,1);
    e_aluwb      = ev(0,0,0,1,0,0,1,0,2'b00,2'b00,3'b010,0);
    e_branch_z   = ev(1,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0);
    e_branch_nz  = ev(0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0);
    e_addiex     = ev(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0);
    e_addiwb     = ev(0,0,0,1,0,0,0,0,2'b00,2'b00,3'b010,0);
    e_jump       = ev(1,0,0,0,0,0,0,0,2'b00,2'b10,3'b010,0);
  end

  // One cycle: drive inputs just after the edge, queue what the DUT must show this cycle.
  task automatic step(input string name, input logic rst, input logic [5:0] op,
                      input logic [5:0] funct, input logic zero, input logic mr,
                      input logic [15:0] exp);
    item_t it;
    reset         = rst;
    bus.op        = op;
    bus.funct     = funct;
    bus.zero      = zero;
    bus.mem_ready = mr;
    it.name = name;
    it.exp  = exp;
    sb_q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      item_t it;
      logic [15:0] got;
      it  = sb_q.pop_front();
      got = {bus.pcen, bus.irwrite, bus.memwrite, bus.regwrite, bus.iord, bus.memtoreg,
             bus.regdst, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol, bus.illegal};
      checks++;
      if (got !== it.exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b", it.name, got, it.exp);
      end else begin
        $display("ok   %s: %b", it.name, got);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111, SUBF = 6'b100010, Z6 = 6'b000000;

  initial begin
    reset = 1'b1;
    bus.op = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step("reset0", 1, Z6, Z6, 0, 1, e_reset);
    step("reset1", 1, Z6, Z6, 0, 1, e_reset);

    // lw, no wait states: 5 cycles
    step("lw_fetch",   0, LW, Z6, 0, 1, e_fetch);
    step("lw_decode",  0, LW, Z6, 0, 1, e_decode);
    step("lw_memadr",  0, LW, Z6, 0, 1, e_memadr);
    step("lw_memread", 0, LW, Z6, 0, 1, e_memread);
    step("lw_memwb",   0, LW, Z6, 0, 1, e_memwb);

    // R-type sub
    step("sub_fetch",  0, RT, SUBF, 0, 1, e_fetch);
    step("sub_decode", 0, RT, SUBF, 0, 1, e_decode);
    step("sub_exec",   0, RT, SUBF, 0, 1, e_exec_sub);
    step("sub_aluwb",  0, RT, SUBF, 0, 1, e_aluwb);

    // beq taken then not taken
    step("beq1_fetch",  0, BEQ, Z6, 1, 1, e_fetch);
    step("beq1_decode", 0, BEQ, Z6, 1, 1, e_decode);
    step("beq1_branch", 0, BEQ, Z6, 1, 1, e_branch_z);
    step("beq0_fetch",  0, BEQ, Z6, 0, 1, e_fetch);
    step("beq0_decode", 0, BEQ, Z6, 0, 1, e_decode);
    step("beq0_branch", 0, BEQ, Z6, 0, 1, e_branch_nz);

    // sw with 3 wait states in MEMWRITE
    step("sw_fetch",   0, SW, Z6, 0, 1, e_fetch);
    step("sw_decode",  0, SW, Z6, 0, 1, e_decode);
    step("sw_memadr",  0, SW, Z6, 0, 1, e_memadr);
    for (int i = 0; i < 3; i++) step($sformatf("sw_wait%0d", i), 0, SW, Z6, 0, 0, e_memwrite);
    step("sw_done",    0, SW, Z6, 0, 1, e_memwrite);

    // illegal op, then illegal funct
    step("badop_fetch",  0, BAD, Z6, 0, 1, e_fetch);
    step("badop_decode", 0, BAD, Z6, 0, 1, e_decode_ill);
    step("badfn_fetch",  0, RT, Z6, 0, 1, e_fetch);
    step("badfn_decode", 0, RT, Z6, 0, 1, e_decode);
    step("badfn_exec",   0, RT, Z6, 0, 1, e_exec_ill);

    // addi and j; FETCH wait state first
    step("addi_fwait", 0, ADDI, Z6, 0, 0, e_fetch_wait);
    step("addi_fetch", 0, ADDI, Z6, 0, 1, e_fetch);
    step("addi_decode",0, ADDI, Z6, 0, 1, e_decode);
    step("addi_ex",    0, ADDI, Z6, 0, 1, e_addiex);
    step("addi_wb",    0, ADDI, Z6, 0, 1, e_addiwb);
    step("j_fetch",    0, JMP, Z6, 0, 1, e_fetch);
    step("j_decode",   0, JMP, Z6, 0, 1, e_decode);
    step("j_jump",     0, JMP, Z6, 0, 1, e_jump);

    // lw with one MEMREAD wait, then reset during MEMREAD
    step("lww_fetch",  0, LW, Z6, 0, 1, e_fetch);
    step("lww_decode", 0, LW, Z6, 0, 1, e_decode);
    step("lww_memadr", 0, LW, Z6, 0, 1, e_memadr);
    step("lww_wait",   0, LW, Z6, 0, 0, e_memread);
    step("lww_rdrst",  1, LW, Z6, 0, 1, e_reset);
    step("post_fetch", 0, ADDI, Z6, 0, 1, e_fetch);
    step("post_decode",0, ADDI, Z6, 0, 1, e_decode);
    step("post_ex",    0, ADDI, Z6, 0, 1, e_addiex);
    step("post_wb",    0, ADDI, Z6, 0, 1, e_addiwb);
    step("idle_fetch", 0, ADDI, Z6, 0, 1, e_fetch);

    for (int i = 0; i < 100 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore FSM that sequences the shared multicycle MIPS datapath (ALU, register file, unified instruction/data memory, PC, IR) one state per cycle.
- Decodes op/funct and drives ALU operand selects, alucontrol and all write enables.
- Stalls on memory wait states via mem_ready.
- Sits beside the datapath in the CPU top level; the only source of control for the ALU.

Parameters:
- none; opcode, funct, ALU and state encodings are fixed constants in the package.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- op  in  6  instr[31:26] from IR
- funct  in  6  instr[5:0] from IR
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes access this cycle
- pcen  out  1  PC write enable (pcwrite | (branch & zero))
- irwrite  out  1  IR load
- memwrite  out  1  memory write strobe
- regwrite  out  1  register file write
- iord  out  1  0: address=PC, 1: address=ALUOut
- memtoreg  out  1  write-back data: 0 ALUOut, 1 MDR
- regdst  out  1  dest reg: 0 rt, 1 rd
- alusrca  out  1  srca: 0 PC, 1 regA
- alusrcb  out  2  srcb: 00 regB, 01 const 4, 10 signimm, 11 signimm<<2
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- alucontrol  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt
- illegal  out  1  one-cycle pulse on unsupported op/funct

Behaviour:
- Reset: while reset=1 at a rising edge, next state is FETCH and op_q/funct_q clear to 0. While reset is high, every output is forced to 0, including pcen, irwrite, memwrite, regwrite and illegal. Reset mid-instruction abandons it; no write occurs in the reset cycle.
- Outputs are combinational from state (plus zero, mem_ready, op_q, funct_q). Undriven selects are 0 and alucontrol defaults to 010.
- States and outputs:
- FETCH: iord=0, alusrca=0, alusrcb=01, add. If mem_ready: irwrite=1, pcwrite=1, go to DECODE; else hold FETCH with no enables.
- DECODE: alusrca=0, alusrcb=11, add (branch target into ALUOut). Latch op_q=op, funct_q=funct.
  - DECODE routing: lw/sw -> MEMADR; R-type -> EXECUTE; beq -> BRANCH; addi -> ADDIEX; j -> JUMP.
  - Any other op: illegal=1 and go to FETCH.
- MEMADR: alusrca=1, alusrcb=10, add. Next: lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: iord=1. Hold until mem_ready, then MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1, then FETCH.
- MEMWRITE: iord=1, memwrite=1 held until mem_ready. The strobe stays high through wait states; go to FETCH on the mem_ready cycle.
- EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct_q:
  - add 100000 -> 010, sub 100010 -> 110, and 100100 -> 000, or 100101 -> 001, slt 101010 -> 111.
  - Legal funct -> ALUWB. Unknown funct -> illegal=1, go to FETCH (no write).
- ALUWB: regdst=1, memtoreg=0, regwrite=1, then FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1, so pcen=zero. Then FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add, then ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1, then FETCH.
- JUMP: pcsrc=10, pcwrite=1, then FETCH.
- Latency with zero wait states: lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles. Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Illegal states (unused encodings) go to FETCH with all outputs 0.
- mem_ready is ignored in states other than FETCH, MEMREAD and MEMWRITE.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state encoding (4-bit, 12 states);
  - opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010;
  - funct codes;
  - ALU control codes;
  - alusrcb and pcsrc select codes.
- One sub-module, alu_decoder: combinational funct -> alucontrol plus funct_illegal flag. It is instantiated once and used in EXECUTE.

Test Plan:
- Reset held 2 cycles, released, mem_ready=1, op=100011: states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. regwrite=1 with memtoreg=1 only in cycle 5; irwrite=1 only in cycle 1.
- R-type funct=100010 (sub): EXECUTE shows alucontrol=110, alusrca=1, alusrcb=00. ALUWB has regdst=1, regwrite=1. Next FETCH at cycle 5.
- beq run twice, zero=1 then zero=0: pcen=1, pcsrc=01 in BRANCH cycle for the first; pcen=0 for the second. Both return to FETCH.
- sw with mem_ready low for 3 cycles in MEMWRITE: memwrite=1, iord=1 for 4 consecutive cycles. FETCH follows the mem_ready cycle; regwrite never set.
- op=111111 then R-type funct=000000: illegal pulses exactly one cycle (in DECODE for the op, in EXECUTE for the funct). No write enable asserted; back to FETCH.
- reset asserted during MEMREAD of lw: all outputs 0 that cycle, no regwrite. FETCH next cycle; op_q cleared.
